// File: rtl/wdpm_pkg.sv
//------------------------------------------------------------------------------
// Module      : wdpm_pkg
// Description : Shared opcode, register-code, field-position and state types
//               for the fetch/decode front end.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package wdpm_pkg;

    localparam int c_op_hi  = 15;
    localparam int c_op_lo  = 12;
    localparam int c_reg_hi = 11;
    localparam int c_reg_lo = 8;
    localparam int c_imm_hi = 7;
    localparam int c_imm_lo = 0;
    localparam int c_jmp_lo = 3;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_OR  = 4'h2,
        OP_AND = 4'h3,
        OP_XOR = 4'h4,
        OP_NOT = 4'h5,
        OP_ST  = 4'h6,
        OP_LD  = 4'h7,
        OP_NOP = 4'hA,
        OP_JMP = 4'hF
    } opcode_e;

    localparam logic [3:0] c_reg_r0  = 4'h0;
    localparam logic [3:0] c_reg_r1  = 4'h1;
    localparam logic [3:0] c_reg_r2  = 4'h2;
    localparam logic [3:0] c_reg_r3  = 4'h3;
    localparam logic [3:0] c_reg_id  = 4'h4;
    localparam logic [3:0] c_reg_dm0 = 4'hC;
    localparam logic [3:0] c_reg_dm1 = 4'hD;
    localparam logic [3:0] c_reg_dm2 = 4'hE;
    localparam logic [3:0] c_reg_dm3 = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2
    } fetch_state_e;

    // Every opcode with the top bit clear goes to the execute stage.
    function automatic logic is_issuable(input logic [3:0] op);
        return ~op[3];
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_decode.sv
//------------------------------------------------------------------------------
// Module      : instr_decode
// Description : Combinational split of a 16-bit instruction word into fields
//               and internal-opcode classification.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_decode
    import wdpm_pkg::*;
#(
    parameter int PC_WIDTH = 5
) (
    input  logic [15:0]         word,
    output logic [3:0]          op,
    output logic [3:0]          reg_code,
    output logic [7:0]          imm,
    output logic [PC_WIDTH-1:0] jmp_target,
    output logic                is_nop,
    output logic                is_jmp,
    output logic                is_illegal
);

    assign op         = word[c_op_hi:c_op_lo];
    assign reg_code   = word[c_reg_hi:c_reg_lo];
    assign imm        = word[c_imm_hi:c_imm_lo];
    assign jmp_target = word[c_jmp_lo +: PC_WIDTH];

    assign is_nop     = (op == OP_NOP);
    assign is_jmp     = (op == OP_JMP);
    // Upper half of the opcode space minus NOP and JMP is undefined.
    assign is_illegal = op[3] && !is_nop && !is_jmp;

endmodule

`default_nettype wire

// File: rtl/fetch_decode.sv
//------------------------------------------------------------------------------
// Module      : fetch_decode
// Description : Instruction fetch/decode front end: PC, instruction register,
//               FETCH/ISSUE sequencing and retired-instruction counter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_decode
    import wdpm_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int PC_WIDTH   = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  EN,
    output logic [PC_WIDTH-1:0]   PM_ADDR,
    input  logic [DATA_WIDTH-1:0] PM_DATA,
    output logic [3:0]            OP_CODE,
    output logic [3:0]            REG_CODE,
    output logic [7:0]            IMM,
    output logic                  VALID,
    input  logic                  READY,
    output logic                  ILLEGAL,
    output logic [CNT_WIDTH-1:0]  INSTR_CNT
);

    fetch_state_e        r_state;
    fetch_state_e        w_state_next;
    logic [PC_WIDTH-1:0] r_pc;
    logic [3:0]          r_op;
    logic [3:0]          r_reg;
    logic [7:0]          r_imm;
    logic                r_illegal;
    logic [CNT_WIDTH-1:0] r_cnt;

    logic [3:0]          w_dec_op;
    logic [3:0]          w_dec_reg;
    logic [7:0]          w_dec_imm;
    logic [PC_WIDTH-1:0] w_dec_jmp_target;
    logic                w_dec_is_nop;
    logic                w_dec_is_jmp;
    logic                w_dec_is_illegal;

    instr_decode #(
        .PC_WIDTH   (PC_WIDTH)
    ) u_decode (
        .word       (PM_DATA),
        .op         (w_dec_op),
        .reg_code   (w_dec_reg),
        .imm        (w_dec_imm),
        .jmp_target (w_dec_jmp_target),
        .is_nop     (w_dec_is_nop),
        .is_jmp     (w_dec_is_jmp),
        .is_illegal (w_dec_is_illegal)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (EN) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (is_issuable(w_dec_op)) begin
                    w_state_next = S_ISSUE;
                end else begin
                    w_state_next = EN ? S_FETCH : S_IDLE;
                end
            end
            S_ISSUE: begin
                // EN only matters once the pending instruction has transferred.
                if (READY) begin
                    w_state_next = EN ? S_FETCH : S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // The IR is held directly as its three field registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_pc      <= '0;
            r_op      <= '0;
            r_reg     <= '0;
            r_imm     <= '0;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_op  <= w_dec_op;
                    r_reg <= w_dec_reg;
                    r_imm <= w_dec_imm;
                    if (w_dec_is_jmp) begin
                        r_pc <= w_dec_jmp_target;
                    end else if (w_dec_is_nop || w_dec_is_illegal) begin
                        r_pc <= r_pc + PC_WIDTH'(1);
                    end
                    if (w_dec_is_illegal) begin
                        r_illegal <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (READY) begin
                        r_pc  <= r_pc + PC_WIDTH'(1);
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign PM_ADDR   = r_pc;
    assign OP_CODE   = r_op;
    assign REG_CODE  = r_reg;
    assign IMM       = r_imm;
    assign VALID     = (r_state == S_ISSUE);
    assign ILLEGAL   = r_illegal;
    assign INSTR_CNT = r_cnt;

endmodule

`default_nettype wire

// File: doc/fetch_decode.md
Name: fetch_decode

Overview:
- Instruction fetch/decode front end: owns the program counter and drives the program-memory read address.
- Captures the returned 16-bit instruction word and splits it into opcode, register code and immediate.
- Resolves NOP, JMP and undefined opcodes internally; presents ALU/LD/ST instructions to the execute stage over a valid/ready handshake.
- Sits between the program memory (combinational read, 32 words) and the execute/register-file stage.

Parameters:
DATA_WIDTH, 16, instruction word width
PC_WIDTH, 5, program counter width; program memory depth 2**PC_WIDTH
CNT_WIDTH, 16, width of retired-instruction counter

Ports:
CLK  input  1  clock, all state on rising edge
RST_N  input  1  synchronous active-low reset, sampled on rising edge of CLK
EN  input  1  run enable; low parks the unit in IDLE at the next instruction boundary
PM_ADDR  output  PC_WIDTH  program memory read address (= PC)
PM_DATA  input  DATA_WIDTH  program memory read data, combinational from PM_ADDR
OP_CODE  output  4  decoded opcode of issued instruction
REG_CODE  output  4  decoded register code (R0-R3, ID, DM0-DM3)
IMM  output  8  decoded 8-bit value field
VALID  output  1  issued instruction fields are valid
READY  input  1  execute stage accepts issued instruction
ILLEGAL  output  1  sticky: an undefined opcode was fetched
INSTR_CNT  output  CNT_WIDTH  count of instructions accepted by execute

Behaviour:
- Field map: OP=[15:12], REG=[11:8], IMM=[7:0]; JMP target=[7:3], [2:0] reserved and ignored.
- Opcodes: 0000 ADD, 0001 SUB, 0010 OR, 0011 AND, 0100 XOR, 0101 NOT, 0110 ST, 0111 LD are issued. 1010 NOP and 1111 JMP are consumed internally. 1000, 1001 and 1011-1110 are undefined.
- Reset (RST_N=0 at clock edge), from any state including mid-handshake:
  - PC=0, IR=0, state=IDLE, VALID=0.
  - OP_CODE/REG_CODE/IMM=0, ILLEGAL=0, INSTR_CNT=0.
- PM_ADDR is always PC (combinational). No output other than PM_ADDR depends combinationally on an input.
- FSM states: IDLE, FETCH, ISSUE.
  - IDLE: VALID=0. If EN=1, go to FETCH; else stay.
  - FETCH (1 cycle): IR<=PM_DATA, then classify:
    - Issuable: go to ISSUE.
    - NOP: PC<=PC+1.
    - JMP: PC<=target; REG_CODE ignored; unconditional.
    - Undefined: treated as NOP, and ILLEGAL<=1.
    - For NOP, JMP and undefined: next state is FETCH if EN=1, else IDLE.
  - ISSUE: VALID=1; OP_CODE/REG_CODE/IMM driven from registered IR fields, stable while VALID=1 and READY=0.
    - On a cycle with READY=1: PC<=PC+1, INSTR_CNT<=INSTR_CNT+1. Next state is FETCH if EN=1, else IDLE.
    - READY=0: hold all outputs, no PC change.
- Handshake: transfer occurs on a clock edge with VALID=1 and READY=1. VALID never deasserts without a transfer (except on reset). EN=0 during ISSUE does not cancel the pending issue.
- Latency: issued instruction takes 2 cycles minimum (FETCH+ISSUE); NOP/JMP/undefined take 1 cycle each.
- Output registers: OP_CODE/REG_CODE/IMM are registered and retain the last IR fields after leaving ISSUE; only VALID qualifies them.
- Width rules:
  - PC increment wraps modulo 2**PC_WIDTH (31 -> 0).
  - INSTR_CNT wraps at 2**CNT_WIDTH.
  - JMP target is exactly PC_WIDTH bits; no bounds check is needed.
- JMP to its own address is a legal halt loop: one FETCH per cycle, VALID stays 0.
- ILLEGAL is cleared only by reset.

Decomposition:
- Package wdpm_pkg:
  - opcode enum (4-bit), reg_code constants (R0-R3, ID, DM0-DM3)
  - field bit-position localparams
  - fetch-state enum {IDLE, FETCH, ISSUE}
  - function is_issuable(op)
- One sub-module, instr_decode: combinational.
  - Input: 16-bit word.
  - Outputs: op, reg, imm, jmp_target, is_nop, is_jmp, is_illegal.
- fetch_decode holds the PC, IR, FSM and counter.

Test Plan:
- Reset/start: hold RST_N=0 for 2 cycles, then EN=1, READY=1, MEM[0]=16'h0105 -> PM_ADDR=0. VALID=1 in the 2nd cycle after EN with OP_CODE=0, REG_CODE=1, IMM=8'h05. INSTR_CNT=1 and PM_ADDR=1 after the transfer.
- Backpressure: MEM[1]=16'h7C2A (LD DM0), READY=0 for 4 cycles -> VALID stays 1, fields stable (7, C, 2A), PC stays 1. Raise READY -> single transfer, PC=2.
- NOP/JMP: MEM[2]=16'hA000, MEM[3]=16'hF018 -> NOP and JMP take 1 cycle each with VALID=0. PM_ADDR goes 2 -> 3 -> 3 (self-jump), holding at 3 with INSTR_CNT unchanged.
- Wrap and illegal: MEM[30]=16'h8000, MEM[31]=16'h4203, start at PC=30 via JMP -> ILLEGAL=1, no issue for 30. Issue XOR REG=2 IMM=03, then PM_ADDR=0.
- Mid-operation reset: assert RST_N=0 for one cycle while VALID=1, READY=0 -> next cycle VALID=0, PM_ADDR=0, ILLEGAL=0, INSTR_CNT=0, state IDLE.
- EN drop: EN=0 during ISSUE -> the pending instruction still transfers on READY, then IDLE with VALID=0. PC advanced by 1; no further fetch until EN=1.
